// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART peripheral: the FSM state encoding
// used by both the transmitter and the receiver, and the frame geometry.
// No ports.
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } UART_STATE_t;

    // Data bits per 8N1 frame.
    localparam int UART_FRAME_BITS = 8;

    // Width of the data-bit index inside a frame.
    localparam int UART_BIT_IDX_W = $clog2(UART_FRAME_BITS);

    // Index of the last data bit, sized to the bit index counter.
    localparam logic [UART_BIT_IDX_W-1:0] UART_LAST_BIT = UART_BIT_IDX_W'(UART_FRAME_BITS - 1);

endpackage : uart_pkg

// File: rtl/uart_if.sv
// ---------------------------------------------------------------------------
// uart_if
// Register-side handshake between the memory controller and the UART
// peripheral.
//   master (memory controller): drives tx_send, tx_data, rx_clear;
//                               reads busy, rx_flag, rx_data, rx_overrun,
//                               rx_frame_err.
//   slave  (uart_peripheral):   the mirror image.
// ---------------------------------------------------------------------------
interface uart_if;

    logic        tx_send;       // one-cycle request to transmit tx_data
    logic [7:0]  tx_data;       // byte to transmit, sampled on acceptance
    logic        rx_clear;      // acknowledge: clears rx_flag and rx_overrun
    logic        busy;          // transmitter not idle
    logic        rx_flag;       // received byte valid, sticky
    logic [31:0] rx_data;       // last received byte, zero-extended
    logic        rx_overrun;    // sticky: byte arrived while rx_flag was set
    logic        rx_frame_err;  // one-cycle pulse: stop bit sampled low

    modport master (
        output tx_send, tx_data, rx_clear,
        input  busy, rx_flag, rx_data, rx_overrun, rx_frame_err
    );

    modport slave (
        input  tx_send, tx_data, rx_clear,
        output busy, rx_flag, rx_data, rx_overrun, rx_frame_err
    );

endinterface : uart_if

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Bit-period timer shared by the TX and RX state machines (one per direction).
// Counts 0..CLKS_PER_BIT-1 and raises tick in the last cycle of the period;
// the count wraps to 0 on the tick so consecutive bits need no restart.
//   clk, rst  : clock, asynchronous active-high reset
//   restart   : forces the count back to 0 on the next edge (state entry)
//   half      : use the CLKS_PER_BIT/2 terminal count (RX start-bit centre)
//   tick      : terminal count reached this cycle
// ---------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic half,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every signal driven here gets a value on every path (defaults first
    // in larger blocks); a path that leaves one unassigned infers a latch.
    always_comb begin
        tick  = (cnt_q == (half ? HALF_TC : FULL_TC));
        cnt_d = (restart || tick) ? '0 : cnt_q + CNT_W'(1);
    end

    // NOTE: clocked blocks use non-blocking assignments only, so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : uart_bit_timer

// File: rtl/uart_peripheral.sv
// ---------------------------------------------------------------------------
// uart_peripheral
// 8N1 UART transmitter and receiver behind the memory-mapped UART registers.
//   clk, rst   : system clock, asynchronous active-high reset
//   bus        : uart_if.slave - tx_send/tx_data/rx_clear in,
//                busy/rx_flag/rx_data/rx_overrun/rx_frame_err out
//   uart_rxd   : serial input pin, asynchronous to clk
//   uart_txd   : serial output pin, idle high
// All outputs come straight from flops. TX and RX are independent.
// ---------------------------------------------------------------------------
module uart_peripheral
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic   clk,
    input  logic   rst,
    uart_if.slave  bus,
    input  logic   uart_rxd,
    output logic   uart_txd
);

    // -----------------------------------------------------------------------
    // Transmitter
    // -----------------------------------------------------------------------
    UART_STATE_t               tx_state_q, tx_state_d;
    logic [7:0]                tx_shift_q, tx_shift_d;
    logic [UART_BIT_IDX_W-1:0] tx_bit_q,   tx_bit_d;
    logic                      tx_txd_q,   tx_txd_d;
    logic                      tx_busy_q,  tx_busy_d;
    logic                      tx_tick;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (tx_state_d != tx_state_q),
        .half    (1'b0),
        .tick    (tx_tick)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        unique case (tx_state_q)
            IDLE: begin
                // Sends are only looked at here, so a send while busy is dropped.
                if (bus.tx_send) begin
                    tx_shift_d = bus.tx_data;
                    tx_state_d = START;
                end
            end
            START: begin
                if (tx_tick) begin
                    tx_bit_d   = '0;
                    tx_state_d = DATA;
                end
            end
            DATA: begin
                if (tx_tick) begin
                    if (tx_bit_q == UART_LAST_BIT) begin
                        tx_state_d = STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + UART_BIT_IDX_W'(1);
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end
            end
            STOP: begin
                if (tx_tick) begin
                    tx_state_d = IDLE;
                end
            end
        endcase
        // Line level and busy are derived from the next state so they change
        // on the same edge as the state itself.
        tx_busy_d = (tx_state_d != IDLE);
        tx_txd_d  = (tx_state_d == DATA) ? tx_shift_d[0] : (tx_state_d != START);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_txd_q   <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_txd_q   <= tx_txd_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    // -----------------------------------------------------------------------
    // Receiver
    // -----------------------------------------------------------------------
    logic [1:0]                rx_sync_q, rx_sync_d;
    logic                      rxd_s;
    UART_STATE_t               rx_state_q, rx_state_d;
    logic [7:0]                rx_shift_q, rx_shift_d;
    logic [UART_BIT_IDX_W-1:0] rx_bit_q,   rx_bit_d;
    logic [7:0]                rx_byte_q,  rx_byte_d;
    logic                      rx_flag_q,  rx_flag_d;
    logic                      rx_ovr_q,   rx_ovr_d;
    logic                      rx_err_q,   rx_err_d;
    logic                      rx_tick;

    // Two-flop synchronizer; idles high like the line so reset is not a start bit.
    assign rx_sync_d = {rx_sync_q[0], uart_rxd};
    assign rxd_s     = rx_sync_q[1];

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (rx_state_d != rx_state_q),
        .half    (rx_state_q == START),
        .tick    (rx_tick)
    );

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        rx_byte_d  = rx_byte_q;
        rx_flag_d  = rx_flag_q;
        rx_ovr_d   = rx_ovr_q;
        rx_err_d   = 1'b0;
        if (bus.rx_clear) begin
            rx_flag_d = 1'b0;
            rx_ovr_d  = 1'b0;
        end
        unique case (rx_state_q)
            IDLE: begin
                if (!rxd_s) begin
                    rx_state_d = START;
                end
            end
            START: begin
                // Mid start bit: still low means a real frame, high was a glitch.
                if (rx_tick) begin
                    rx_bit_d   = '0;
                    rx_state_d = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_tick) begin
                    rx_shift_d = {rxd_s, rx_shift_q[7:1]};
                    if (rx_bit_q == UART_LAST_BIT) begin
                        rx_state_d = STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + UART_BIT_IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (rx_tick) begin
                    rx_state_d = IDLE;
                    if (rxd_s) begin
                        // Completion overrides a coincident rx_clear.
                        rx_byte_d = rx_shift_q;
                        rx_flag_d = 1'b1;
                        rx_ovr_d  = !bus.rx_clear && (rx_ovr_q || rx_flag_q);
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= IDLE;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_byte_q  <= '0;
            rx_flag_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_sync_q  <= rx_sync_d;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_byte_q  <= rx_byte_d;
            rx_flag_q  <= rx_flag_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_err_q   <= rx_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign uart_txd         = tx_txd_q;
    assign bus.busy         = tx_busy_q;
    assign bus.rx_flag      = rx_flag_q;
    assign bus.rx_data      = {24'h0, rx_byte_q};
    assign bus.rx_overrun   = rx_ovr_q;
    assign bus.rx_frame_err = rx_err_q;

endmodule : uart_peripheral

// File: tb/tb_uart_peripheral.sv
// ---------------------------------------------------------------------------
// tb_uart_peripheral
// Self-checking bench for uart_peripheral with CLKS_PER_BIT=8. A frame-level
// reference model (TX: position inside the 10-bit frame; RX: a queue of
// frames driven onto the line with their expected completion cycle) is
// compared against every DUT output on every falling edge, and a set of
// hand-computed literal expectations pins the model itself.
// ---------------------------------------------------------------------------
module tb_uart_peripheral;

    localparam int CPB = 8;
    // Line-low to completion: 2 synchronizer edges + 1 edge to leave IDLE,
    // half a bit to the start-bit centre, 8 data bits and the stop bit.
    localparam int RX_LAT = 3 + CPB / 2 + 9 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_rxd = 1'b1;
    logic uart_txd;

    uart_if bus ();

    uart_peripheral #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        logic [7:0] b;
        bit         ok;
    } rx_item_t;

    rx_item_t   rxq[$];
    int         cyc       = 0;
    bit         m_tx_act  = 1'b0;
    int         m_tx_k    = 0;
    logic [9:0] m_tx_frame = 10'h3FF;
    bit         m_flag    = 1'b0;
    bit         m_ovr     = 1'b0;
    bit         m_err     = 1'b0;
    logic [7:0] m_byte    = 8'h00;

    always @(posedge clk or posedge rst) begin
        bit old_flag, old_ovr;
        if (rst) begin
            m_tx_act = 1'b0;
            m_tx_k   = 0;
            m_flag   = 1'b0;
            m_ovr    = 1'b0;
            m_err    = 1'b0;
            m_byte   = 8'h00;
            rxq.delete();
        end else begin
            cyc++;
            // TX: a frame is 10 bits of CPB cycles; sends only land when idle.
            if (m_tx_act) begin
                m_tx_k++;
                if (m_tx_k == 10 * CPB) m_tx_act = 1'b0;
            end else if (bus.tx_send) begin
                m_tx_act   = 1'b1;
                m_tx_k     = 0;
                m_tx_frame = {1'b1, bus.tx_data, 1'b0};
            end
            // RX register-level rules.
            old_flag = m_flag;
            old_ovr  = m_ovr;
            m_err    = 1'b0;
            if (bus.rx_clear) begin
                m_flag = 1'b0;
                m_ovr  = 1'b0;
            end
            if (rxq.size() > 0 && rxq[0].due == cyc) begin
                if (rxq[0].ok) begin
                    m_byte = rxq[0].b;
                    m_flag = 1'b1;
                    m_ovr  = bus.rx_clear ? 1'b0 : (old_ovr | old_flag);
                end else begin
                    m_err = 1'b1;
                end
                void'(rxq.pop_front());
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("txd",       32'(uart_txd),        m_tx_act ? 32'(m_tx_frame[m_tx_k / CPB]) : 32'd1);
            check("busy",      32'(bus.busy),        32'(m_tx_act));
            check("rx_flag",   32'(bus.rx_flag),     32'(m_flag));
            check("rx_data",   bus.rx_data,          {24'h0, m_byte});
            check("rx_overrun", 32'(bus.rx_overrun), 32'(m_ovr));
            check("rx_frame_err", 32'(bus.rx_frame_err), 32'(m_err));
        end
    end

    int err_cnt = 0;
    always @(negedge clk) if (bus.rx_frame_err === 1'b1) err_cnt++;

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.tx_data = b;
        bus.tx_send = 1'b1;
        cycles(1);
        bus.tx_send = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.rx_clear = 1'b1;
        cycles(1);
        bus.rx_clear = 1'b0;
    endtask

    // Drives one frame starting now; returns one cycle after the stop bit ends.
    task automatic rx_frame(input logic [7:0] b, input bit stop_ok);
        rx_item_t it;
        it.due = cyc + RX_LAT;
        it.b   = b;
        it.ok  = stop_ok;
        rxq.push_back(it);
        for (int i = 0; i < 10; i++) begin
            uart_rxd = (i == 0) ? 1'b0 : (i == 9) ? stop_ok : b[i-1];
            cycles(CPB);
        end
        uart_rxd = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] wave;
        wave         = '0;
        bus.tx_send  = 1'b0;
        bus.tx_data  = 8'h00;
        bus.rx_clear = 1'b0;
        #1;
        rst    = 1'b1;
        #1;
        cmp_en = 1'b1;
        cycles(3);
        rst = 1'b0;

        // Reset state.
        check("rst_txd",  32'(uart_txd),         1);
        check("rst_busy", 32'(bus.busy),         0);
        check("rst_flag", 32'(bus.rx_flag),      0);
        check("rst_data", bus.rx_data,           0);
        check("rst_ovr",  32'(bus.rx_overrun),   0);
        check("rst_ferr", 32'(bus.rx_frame_err), 0);

        // Idle 50 cycles.
        for (int i = 0; i < 50; i++) begin
            check("idle_txd",  32'(uart_txd),    1);
            check("idle_busy", 32'(bus.busy),    0);
            check("idle_flag", 32'(bus.rx_flag), 0);
            check("idle_data", bus.rx_data,      0);
            cycles(1);
        end

        // Transmit 0xA5; a send of 0x3C mid-frame must be ignored.
        send(8'hA5);
        check("busy_rise", 32'(bus.busy), 1);
        for (int k = 0; k < 10 * CPB; k++) begin
            if (k % CPB == CPB / 2) wave[k / CPB] = uart_txd;
            if (k == 20) begin
                bus.tx_data = 8'h3C;
                bus.tx_send = 1'b1;
            end
            if (k == 21) bus.tx_send = 1'b0;
            if (k == 10 * CPB - 1) check("busy_last_stop", 32'(bus.busy), 1);
            cycles(1);
        end
        check("busy_fall_80", 32'(bus.busy), 0);
        check("tx_wave_A5", 32'(wave), 32'h34A);

        // Send in the cycle right after busy falls is accepted.
        send(8'($urandom));
        check("b2b_accept", 32'(bus.busy), 1);
        cycles(10 * CPB);

        // Receive 0x5A, then clear.
        rx_frame(8'h5A, 1'b1);
        check("rx5A_flag", 32'(bus.rx_flag), 1);
        check("rx5A_data", bus.rx_data, 32'h0000_005A);
        pulse_clear();
        check("rx5A_clear", 32'(bus.rx_flag), 0);
        cycles(5);

        // Overrun, then clear coinciding with a completion.
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        check("ovr_data", bus.rx_data, 32'h22);
        check("ovr_set",  32'(bus.rx_overrun), 1);
        fork
            rx_frame(8'h33, 1'b1);
            begin
                repeat (RX_LAT - 1) @(posedge clk);
                #1;
                bus.rx_clear = 1'b1;
                cycles(1);
                bus.rx_clear = 1'b0;
            end
        join
        check("clr_cmp_flag", 32'(bus.rx_flag), 1);
        check("clr_cmp_data", bus.rx_data, 32'h33);
        check("clr_cmp_ovr",  32'(bus.rx_overrun), 0);
        pulse_clear();
        check("pre_glitch_flag", 32'(bus.rx_flag), 0);

        // Two-cycle glitch is not a frame.
        uart_rxd = 1'b0;
        cycles(2);
        uart_rxd = 1'b1;
        cycles(30);
        check("glitch_flag", 32'(bus.rx_flag), 0);

        // Bad stop bit: one error pulse, data untouched.
        err_cnt = 0;
        rx_frame(8'hFF, 1'b0);
        cycles(30);
        check("ferr_pulses", 32'(err_cnt), 1);
        check("ferr_data",   bus.rx_data, 32'h33);
        check("ferr_flag",   32'(bus.rx_flag), 0);

        // Randomized concurrent TX / RX / clear traffic.
        for (int it = 0; it < 8; it++) begin
            fork
                begin
                    send(8'($urandom));
                    cycles($urandom_range(60, 95));
                    send(8'($urandom));
                end
                begin
                    cycles($urandom_range(0, 3));
                    rx_frame(8'($urandom), $urandom_range(0, 3) != 0);
                end
                begin
                    cycles($urandom_range(0, 90));
                    pulse_clear();
                end
            join
            cycles(20 + $urandom_range(0, 10));
        end
        cycles(10 * CPB + 5);

        // Reset mid TX frame takes effect immediately.
        send(8'h96);
        cycles(30);
        rst = 1'b1;
        #1;
        check("midrst_txd",  32'(uart_txd), 1);
        check("midrst_busy", 32'(bus.busy), 0);
        cycles(3);
        rst = 1'b0;
        check("postrst_txd",  32'(uart_txd), 1);
        check("postrst_busy", 32'(bus.busy), 0);
        cycles(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_peripheral
